// File: rtl/can_rx_fetch.sv
// Avalon-MM master that drains received frames from a PeliCAN register window
// and presents each complete frame on a valid/ready port.
module can_rx_fetch #(
   parameter int unsigned POLL_CYCLES    = 100000,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        av_clk,
   input  logic        av_reset,
   input  logic        enable,
   input  logic        can_irq_n,
   output logic [7:0]  m_address,
   output logic        m_chipselect,
   output logic        m_read,
   output logic        m_write,
   output logic [31:0] m_writedata,
   output logic [3:0]  m_byteenable,
   input  logic [31:0] m_readdata,
   input  logic        m_waitrequest_n,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic        frame_ext,
   output logic        frame_rtr,
   output logic [3:0]  frame_dlc,
   output logic [28:0] frame_id,
   output logic [63:0] frame_data,
   output logic [15:0] frame_count,
   output logic        err_timeout
);

   typedef enum logic [2:0] {IDLE, RD_SR, RD_INFO, RD_BYTES, PRESENT, REL, RD_IR} state_t;

   localparam bit          POLL_EN   = (POLL_CYCLES != 0);
   localparam logic [31:0] POLL_LAST = 32'(POLL_CYCLES - 1);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

   state_t      state_reg, state_next;
   logic        gap_reg;
   logic [31:0] poll_reg;
   logic [31:0] to_reg;
   logic [3:0]  idx_reg;
   logic [3:0]  nbytes_reg;
   logic [3:0]  len_reg;
   logic        ext_reg;
   logic        rtr_reg;
   logic [3:0]  dlc_reg;
   logic        frame_ext_reg;
   logic        frame_rtr_reg;
   logic [3:0]  frame_dlc_reg;
   logic [28:0] frame_id_reg;
   logic [63:0] frame_data_reg;
   logic [15:0] count_reg;
   logic        err_reg;

   logic        in_access;
   logic        strobe;
   logic        done;
   logic        abort;
   logic        poll_hit;
   logic        byte_done;
   logic        last_byte;
   logic        load_frame;
   logic [7:0]  rdata;
   logic        info_ext;
   logic        info_rtr;
   logic [3:0]  info_dlc;
   logic [3:0]  info_len;
   logic [3:0]  info_nbytes;
   logic [28:0] asm_id;
   logic [63:0] asm_data;
   logic        unused_bits;

   logic [7:0]  buf_reg   [0:11];
   logic [7:0]  view      [0:11];
   logic [7:0]  data_byte [0:7];

   // One idle cycle (gap_reg) follows every completed or aborted access.
   assign in_access = (state_reg == RD_SR) || (state_reg == RD_INFO) || (state_reg == RD_BYTES) ||
                      (state_reg == REL)   || (state_reg == RD_IR);
   assign strobe    = in_access && !gap_reg;
   assign done      = strobe && m_waitrequest_n;
   assign abort     = strobe && !m_waitrequest_n && (to_reg == TO_LAST);
   assign poll_hit  = POLL_EN && (poll_reg == POLL_LAST);
   assign rdata     = m_readdata[7:0];
   assign unused_bits = ^m_readdata[31:8];

   assign info_ext    = rdata[7];
   assign info_rtr    = rdata[6];
   assign info_dlc    = rdata[3:0];
   assign info_len    = info_rtr ? 4'd0 : ((info_dlc > 4'd8) ? 4'd8 : info_dlc);
   assign info_nbytes = (info_ext ? 4'd4 : 4'd2) + info_len;

   assign byte_done  = done && (state_reg == RD_BYTES);
   assign last_byte  = (idx_reg == nbytes_reg - 4'd1);
   assign load_frame = byte_done && last_byte;

   // The view merges the byte arriving this cycle so the frame can be
   // registered in the same cycle the final byte completes.
   genvar gi;
   for (gi = 0; gi < 12; gi++) begin : g_buf
      assign view[gi] = (byte_done && idx_reg == 4'(gi)) ? rdata : buf_reg[gi];
      always_ff @(posedge av_clk or posedge av_reset) begin
         if (av_reset)
            buf_reg[gi] <= 8'h00;
         else if (byte_done && idx_reg == 4'(gi))
            buf_reg[gi] <= rdata;
      end
   end

   for (gi = 0; gi < 8; gi++) begin : g_data
      assign data_byte[gi] = (4'(gi) >= len_reg) ? 8'h00 : (ext_reg ? view[gi + 4] : view[gi + 2]);
      assign asm_data[8*gi +: 8] = data_byte[gi];
   end

   assign asm_id = ext_reg ? {view[0], view[1], view[2], view[3][7:3]}
                           : {18'h0, view[0], view[1][7:5]};

   always_ff @(posedge av_clk or posedge av_reset) begin
      if (av_reset)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (enable && (!can_irq_n || poll_hit)) state_next = RD_SR;
         RD_SR:    if (done) state_next = rdata[0] ? RD_INFO : RD_IR;
         RD_INFO:  if (done) state_next = RD_BYTES;
         RD_BYTES: if (done && last_byte) state_next = PRESENT;
         PRESENT:  if (frame_ready) state_next = REL;
         REL:      if (done) state_next = RD_SR;
         RD_IR:    if (done) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
      if (abort)
         state_next = IDLE;
   end

   always_comb begin
      m_address   = 8'h00;
      m_writedata = 32'h0;
      case (state_reg)
         RD_SR:    m_address = 8'd2;
         RD_INFO:  m_address = 8'd16;
         RD_BYTES: m_address = 8'd17 + {4'h0, idx_reg};
         REL: begin
            m_address   = 8'd1;
            m_writedata = 32'h0000_0004;
         end
         RD_IR:    m_address = 8'd3;
         default:  m_address = 8'h00;
      endcase
      m_read      = strobe && (state_reg != REL);
      m_write     = strobe && (state_reg == REL);
      frame_valid = (state_reg == PRESENT);
   end

   assign m_chipselect = strobe;
   assign m_byteenable = {3'b000, strobe};
   assign frame_ext    = frame_ext_reg;
   assign frame_rtr    = frame_rtr_reg;
   assign frame_dlc    = frame_dlc_reg;
   assign frame_id     = frame_id_reg;
   assign frame_data   = frame_data_reg;
   assign frame_count  = count_reg;
   assign err_timeout  = err_reg;

   always_ff @(posedge av_clk or posedge av_reset) begin
      if (av_reset) begin
         gap_reg        <= 1'b0;
         poll_reg       <= 32'h0;
         to_reg         <= 32'h0;
         idx_reg        <= 4'h0;
         nbytes_reg     <= 4'h0;
         len_reg        <= 4'h0;
         ext_reg        <= 1'b0;
         rtr_reg        <= 1'b0;
         dlc_reg        <= 4'h0;
         frame_ext_reg  <= 1'b0;
         frame_rtr_reg  <= 1'b0;
         frame_dlc_reg  <= 4'h0;
         frame_id_reg   <= 29'h0;
         frame_data_reg <= 64'h0;
         count_reg      <= 16'h0;
         err_reg        <= 1'b0;
      end else begin
         gap_reg <= done || abort;

         if (state_reg == IDLE && state_next == IDLE && enable && POLL_EN)
            poll_reg <= poll_reg + 32'd1;
         else
            poll_reg <= 32'h0;

         if (strobe && !m_waitrequest_n && !abort)
            to_reg <= to_reg + 32'd1;
         else
            to_reg <= 32'h0;

         if (abort)
            err_reg <= 1'b1;

         if (done && state_reg == RD_INFO) begin
            ext_reg    <= info_ext;
            rtr_reg    <= info_rtr;
            dlc_reg    <= info_dlc;
            len_reg    <= info_len;
            nbytes_reg <= info_nbytes;
            idx_reg    <= 4'h0;
         end else if (byte_done) begin
            idx_reg <= idx_reg + 4'd1;
         end

         if (load_frame) begin
            frame_ext_reg  <= ext_reg;
            frame_rtr_reg  <= rtr_reg;
            frame_dlc_reg  <= dlc_reg;
            frame_id_reg   <= asm_id;
            frame_data_reg <= asm_data;
         end

         if (state_reg == PRESENT && frame_ready)
            count_reg <= count_reg + 16'd1;
      end
   end

endmodule

// File: doc/can_rx_fetch.md
Name: can_rx_fetch

Overview:
- Avalon-MM master that drains received frames from the CAN controller's 8-bit PeliCAN register window. It connects to the controller wrapper's Avalon slave port through a point-to-point link.
- Triggers on the controller interrupt or a poll timer. It reads the receive buffer, assembles one complete frame, and presents it on a valid/ready frame port.
- It releases the controller's receive buffer only after the consumer accepts the frame, so the controller FIFO absorbs backpressure.

Parameters:
- POLL_CYCLES, 100000, idle cycles between status polls when no interrupt arrives; 0 disables polling.
- TIMEOUT_CYCLES, 1023, maximum cycles one access may wait for m_waitrequest_n before abort.

Ports:
- av_clk  in  1  clock.
- av_reset  in  1  asynchronous active-high reset.
- enable  in  1  fetch enable; sampled in IDLE only.
- can_irq_n  in  1  controller interrupt, active low.
- m_address  out  8  register address.
- m_chipselect  out  1  high during any access.
- m_read  out  1  read strobe.
- m_write  out  1  write strobe.
- m_writedata  out  32  write data; bits 31:8 are always 0.
- m_byteenable  out  4  fixed 4'b0001.
- m_readdata  in  32  read data; only bits 7:0 are used.
- m_waitrequest_n  in  1  access-complete strobe, high for one cycle.
- frame_valid  out  1  assembled frame available.
- frame_ready  in  1  consumer accepts frame.
- frame_ext  out  1  extended (29-bit) ID.
- frame_rtr  out  1  remote frame.
- frame_dlc  out  4  raw DLC field.
- frame_id  out  29  identifier; standard IDs are right-aligned in bits 10:0.
- frame_data  out  64  data; byte0 in bits 7:0; unused bytes are 0.
- frame_count  out  16  accepted frames, wraps at 65535→0.
- err_timeout  out  1  sticky access timeout flag; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, poll timer 0.
- Access rule:
  - Strobe, address and data stay constant until the cycle m_waitrequest_n=1.
  - Read data is captured in that same cycle.
  - Strobes drop the following cycle; at least one idle cycle separates accesses.
- Timeout: if TIMEOUT_CYCLES elapse with m_waitrequest_n low, the block drops the strobe, sets err_timeout, and returns to IDLE. A partial frame is discarded and frame_valid is not raised.
- IDLE:
  - Requires enable=1.
  - Goes to RD_SR when can_irq_n=0 or the poll timer reaches POLL_CYCLES-1.
  - The poll timer clears on leaving IDLE.
- RD_SR: read address 2.
  - If bit0 (RBS)=1, go to RD_INFO.
  - Otherwise go to RD_IR.
- RD_INFO: read address 16.
  - ext = bit7, rtr = bit6, dlc = bits3:0.
  - Effective data length L = 0 if rtr, else min(dlc,8).
  - Byte count N = 2+L (standard) or 4+L (extended).
- RD_BYTES: read addresses 17 to 16+N, one byte per access.
  - Standard frame: id[10:3] = byte@17, id[2:0] = byte@18 bits7:5.
  - Extended frame: id[28:21] = @17, id[20:13] = @18, id[12:5] = @19, id[4:0] = @20 bits7:3.
  - Data bytes follow the ID bytes in order.
  - Unused frame_data bytes are forced to 0.
- PRESENT: frame_valid=1 with all frame fields registered and stable.
  - The frame transfers in the cycle frame_valid & frame_ready; frame_valid drops the next cycle and frame_count increments.
  - frame_valid never drops without acceptance.
  - enable=0 does not abort a presented frame.
- REL: write 8'h04 (RRB) to address 1, then return to RD_SR to drain further frames.
- RD_IR: read address 3 (clears controller interrupt flags), then go to IDLE.
- Arithmetic: DLC values 9..15 are treated as 8; the frame_dlc output keeps the raw value.
- Reset mid-access: strobes drop immediately (asynchronous reset); any partial frame is lost.

Test Plan:
- Standard data frame: can_irq_n low; SR=0x01, info=0x08, bytes 0xAB,0xE0, data 11..88, then SR=0x00.
  - Reads occur at 2,16,17..26,2,3; write 0x04 to address 1 after acceptance.
  - frame_id=0x55F, frame_data=0x8877665544332211, frame_count=1.
- Extended RTR frame: info=0xC5, ID bytes 12 34 56 78.
  - Exactly 4 ID reads (addresses 17..20).
  - frame_id=0x0246_8ACF, frame_rtr=1, frame_dlc=5, frame_data=0.
- Backpressure: frame_ready low for 50 cycles.
  - frame_valid and fields stay stable; no write to address 1 until acceptance.
- Two buffered frames: SR returns RBS=1 twice, then 0.
  - Two frames delivered, two RRB writes, one IR read, frame_count=2.
- Timeout: m_waitrequest_n held low.
  - After 1023 cycles strobes drop, err_timeout=1, back in IDLE, no frame_valid.
- DLC=12 standard frame and poll trigger: POLL_CYCLES=16, can_irq_n high.
  - SR is read 16 cycles after IDLE entry.
  - 8 data bytes are read; frame_dlc=12.
